// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive watchdog on a two-light traffic controller.
// Tracks light A through verde -> amarelo -> vermelho, measures each phase
// length and raises sticky flags for bad encodings, conflicting greens,
// illegal transitions and wrong phase durations.
module semaforo_monitor #(
  parameter logic [7:0] T_VERDE    = 8'd1,
  parameter logic [7:0] T_AMARELO  = 8'd3,
  parameter logic [7:0] T_VERMELHO = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       err_enc,
  output logic       err_conf,
  output logic       err_seq,
  output logic       err_dur,
  output logic       ok,
  output logic [7:0] ciclos,
  output logic [7:0] ultima_dur
);

  typedef enum logic [1:0] {SYNC, VERDE, AMARELO, VERMELHO} state_t;

  state_t     state;
  state_t     a_state;
  state_t     nxt_legal;
  logic [7:0] dur;
  logic [7:0] tgt;
  logic       parcial;
  logic       a_ok, b_ok, proc, chg, legal;
  logic       v_enc, v_conf, v_seq, v_dur;

  // Decode the current sample and classify the violations it carries.
  always_comb begin
    a_ok      = 1'b0;
    a_state   = SYNC;
    nxt_legal = SYNC;
    tgt       = '0;
    case (A)
      3'b001:  begin a_ok = 1'b1; a_state = VERDE;    end
      3'b010:  begin a_ok = 1'b1; a_state = AMARELO;  end
      3'b100:  begin a_ok = 1'b1; a_state = VERMELHO; end
      default: begin a_ok = 1'b0; a_state = SYNC;     end
    endcase
    b_ok = (B == 3'b001) || (B == 3'b010) || (B == 3'b100);
    case (state)
      VERDE:    begin nxt_legal = AMARELO;  tgt = T_VERDE;    end
      AMARELO:  begin nxt_legal = VERMELHO; tgt = T_AMARELO;  end
      VERMELHO: begin nxt_legal = VERDE;    tgt = T_VERMELHO; end
      default:  begin nxt_legal = SYNC;     tgt = '0;         end
    endcase
    // An invalid encoding on either light suppresses every other check.
    proc   = a_ok && b_ok;
    chg    = proc && (state != SYNC) && (a_state != state);
    legal  = chg && (a_state == nxt_legal);
    v_enc  = !proc;
    v_conf = proc && (A != 3'b100) && (B != 3'b100);
    v_seq  = chg && !legal;
    v_dur  = legal && !parcial && (dur != tgt);
  end

  // Phase tracker, duration counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      dur        <= '0;
      parcial    <= 1'b0;
      err_enc    <= 1'b0;
      err_conf   <= 1'b0;
      err_seq    <= 1'b0;
      err_dur    <= 1'b0;
      ok         <= 1'b1;
      ciclos     <= '0;
      ultima_dur <= '0;
    end else begin
      err_enc  <= err_enc  | v_enc;
      err_conf <= err_conf | v_conf;
      err_seq  <= err_seq  | v_seq;
      err_dur  <= err_dur  | v_dur;
      ok       <= !(err_enc | v_enc | err_conf | v_conf |
                    err_seq | v_seq | err_dur | v_dur);
      if (!a_ok) begin
        state <= SYNC;
        dur   <= '0;
      end else if (b_ok) begin
        if (state == SYNC) begin
          state   <= a_state;
          dur     <= 8'd1;
          parcial <= 1'b1;
        end else if (a_state == state) begin
          dur <= (dur == 8'hFF) ? 8'hFF : dur + 8'd1;
        end else if (legal) begin
          ultima_dur <= dur;
          parcial    <= 1'b0;
          state      <= a_state;
          dur        <= 8'd1;
          if (state == VERMELHO) ciclos <= ciclos + 8'd1;
        end else begin
          state   <= a_state;
          dur     <= 8'd1;
          parcial <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/semaforo_monitor.md
# semaforo_monitor

Passive checker on the two-light traffic controller's outputs. Samples lights `A` and `B` every clock and tracks light A's phase sequence with a small state machine. Measures each phase's length in cycles against configured durations and raises sticky error flags for illegal encodings, conflicting greens, bad transitions and wrong phase lengths. Sits beside the controller in testbenches and in-system as a safety watchdog; it drives nothing back into the controller.

## Interface
- `T_VERDE`, default 8'd1: required green duration of A, cycles (1..255).
- `T_AMARELO`, default 8'd3: required yellow duration of A, cycles (1..255).
- `T_VERMELHO`, default 8'd2: required red duration of A, cycles (1..255).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `A`, input, 3: light A state, one-hot: 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho.
- `B`, input, 3: light B state, same encoding.
- `err_enc`, output, 1: sticky; A or B sampled non-one-hot.
- `err_conf`, output, 1: sticky; A and B both non-red in the same sample.
- `err_seq`, output, 1: sticky; A took a transition other than verde→amarelo→vermelho→verde.
- `err_dur`, output, 1: sticky; a completed A phase had the wrong length.
- `ok`, output, 1: high when all four error flags are low.
- `ciclos`, output, 8: count of completed A vermelho→verde transitions; wraps 255→0.
- `ultima_dur`, output, 8: length of the most recently completed A phase, in cycles.

## Operation
- **States:** SYNC, VERDE, AMARELO, VERMELHO. `dur` is an internal 8-bit counter that saturates at 255.
- **Reset** (`rst`=1 at an edge): state SYNC, `dur`=0, all error flags 0, `ciclos`=0, `ultima_dur`=0. `ok` is therefore 1. A and B are ignored during that edge.
- **Encoding check:** a sample with A or B not in {001, 010, 100} sets `err_enc`.
  - If A is invalid, the state becomes SYNC and `dur`=0.
  - No further checks run on that sample.
- **Conflict check:** a sample with A≠100 and B≠100 sets `err_conf`. This check runs regardless of state.
- **SYNC:** on the first valid A, load the matching state and set `dur`=1.
  - That partial first phase is never duration-checked.
  - A flag bit (`parcial`) marks it as partial.
- **Same phase** (valid A equals the current state): `dur` = `dur`+1, saturating.
- **Phase change** (valid A differs from the current state):
  - Legal next phase: update `ultima_dur`←`dur`.
  - Unless `parcial`, compare `dur` with the T_ value for the phase just ended; a mismatch sets `err_dur`.
  - Clear `parcial`, load the new state, set `dur`=1.
  - If the transition was vermelho→verde, `ciclos`←`ciclos`+1.
  - Illegal next phase (e.g. verde→vermelho): set `err_seq` and load the new state with `dur`=1 and `parcial`=1. Do not check its duration, and do not update `ultima_dur` or `ciclos`.
- **Stickiness:** error flags clear only on `rst`.
- **Simultaneous violations:** all applicable flags set on the same edge.

## Timing
- All outputs are registered.
- A violation present in the sample at edge k is visible on the flags just after edge k, i.e. latency 1 edge from sampling.
- `ultima_dur`, `ciclos` and `err_dur` update at the edge that samples the new phase.
- **Duration** = number of consecutive edges at which A held that value.
- **Saturation:** a phase reaching 255 cycles holds `dur`=255. It is flagged only if the T_ value differs from 255.
- **Reset mid-phase:** everything clears on that edge. The next valid sample starts a SYNC (partial) phase.

## Test plan
- **Nominal sequence:** reset for 2 edges, then A = verde×1, amarelo×3, vermelho×2, verde×1, amarelo×3 with B=100 throughout, except B=001 only while A=100 → all flags 0, `ok`=1. After the second verde sample, `ciclos`=1 and `ultima_dur`=2.
- **Short yellow:** A = verde×1, amarelo×2, vermelho (first phase is partial) → `err_dur`=1 right after the vermelho sample, `ultima_dur`=2. Other flags stay 0.
- **Conflict:** A=001, B=001 for one edge → `err_conf`=1 and `ok`=0 after that edge. Both stay set through later clean cycles until `rst`.
- **Bad encoding and sequence:**
  - A=3'b011 → `err_enc`=1 and state SYNC.
  - Separately, after reset, A = verde then vermelho → `err_seq`=1, `err_dur`=0, `ciclos` unchanged.
- **Reset mid-operation:** assert `rst` during an amarelo phase with `err_dur` set → after that edge all flags 0, `ciclos`=0, `ultima_dur`=0. The first following phase produces no `err_dur` regardless of its length.
- **Wrap:** 256 complete nominal cycles → `ciclos` returns to 0, no flags raised.
